// File: rtl/parity_tx_if.sv
// Handshake and serial-line bundle for parity_tx.
// err_inj exists only when PARITY_TX_ERR_INJ_EN is defined.
interface parity_tx_if;
  logic [3:0] data;
  logic       trig;
  logic       valid;
  logic       ready;
  logic       tx;
  logic       busy;
  logic       done;
`ifdef PARITY_TX_ERR_INJ_EN
  logic       err_inj;
`endif

  modport master (
`ifdef PARITY_TX_ERR_INJ_EN
    output err_inj,
`endif
    output data, trig, valid,
    input  ready, tx, busy, done
  );

  modport slave (
`ifdef PARITY_TX_ERR_INJ_EN
    input  err_inj,
`endif
    input  data, trig, valid,
    output ready, tx, busy, done
  );
endinterface

// File: rtl/parity_tx.sv
// Serial parity-frame transmitter: start, data[0..3], parity, stop; CLKS_PER_BIT clocks per bit.
// Optional PARITY_TX_ERR_INJ_EN adds err_inj, which inverts the parity bit of the accepted frame.
//
// state  | meaning
// IDLE   | line high, ready for a request
// START  | start bit (0) on the line
// DATA   | data[idx] on the line, idx 0..3
// PARITY | parity bit on the line
// STOP   | stop bit (1) on the line; done pulses on exit
module parity_tx #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  parity_tx_if.slave  bus
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       idx, idx_n, idx_inc;
  logic [3:0]       data_q;
  logic             par_q, par_in;
  logic             tx_q, tx_n;
  logic             ready_q, ready_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             load, last;

  // trig=1 selects odd parity, i.e. the even parity of data inverted
`ifdef PARITY_TX_ERR_INJ_EN
  assign par_in = (^bus.data) ^ bus.trig ^ bus.err_inj;
`else
  assign par_in = (^bus.data) ^ bus.trig;
`endif

  assign last    = (cnt == CNT_LAST);
  assign idx_inc = idx + 2'd1;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    tx_n    = tx_q;
    ready_n = ready_q;
    busy_n  = busy_q;
    done_n  = 1'b0;
    load    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.valid && ready_q) begin
          load    = 1'b1;
          state_n = START;
          cnt_n   = '0;
          tx_n    = 1'b0;
          ready_n = 1'b0;
          busy_n  = 1'b1;
        end
      end
      START: begin
        if (last) begin
          cnt_n   = '0;
          idx_n   = 2'd0;
          state_n = DATA;
          tx_n    = data_q[0];
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (last) begin
          cnt_n = '0;
          if (idx == 2'd3) begin
            state_n = PARITY;
            tx_n    = par_q;
          end else begin
            idx_n = idx_inc;
            tx_n  = data_q[idx_inc];
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      PARITY: begin
        if (last) begin
          cnt_n   = '0;
          state_n = STOP;
          tx_n    = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (last) begin
          cnt_n   = '0;
          state_n = IDLE;
          ready_n = 1'b1;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        tx_n    = 1'b1;
        ready_n = 1'b1;
        busy_n  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= 2'd0;
      data_q  <= 4'd0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      tx_q    <= tx_n;
      ready_q <= ready_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      if (load) begin
        data_q <= bus.data;
        par_q  <= par_in;
      end
    end
  end

  assign bus.tx    = tx_q;
  assign bus.ready = ready_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;

endmodule

// File: tb/tb_parity_tx.sv
// Directed bench for parity_tx: table of frames plus back-to-back and mid-frame reset sequences.
// Define PARITY_TX_ERR_INJ_EN for both DUT and bench to exercise the err_inj path.
module tb_parity_tx;
  localparam int N = 4;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  parity_tx_if bus ();

  parity_tx #(.CLKS_PER_BIT(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] data;
    logic       trig;
    logic [6:0] frame;  // frame[i] is bit i on the line, 0 = start
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called just after the accepting edge; returns just after edge k+7N.
  task automatic check_frame(input logic [6:0] exp, input logic trig_sent, input bit scramble,
                             input logic exp_chk, input string name);
    logic [6:0] rx;
    logic       chk_out;
    rx = '0;
    for (int i = 0; i < 7; i++) begin
      for (int c = 0; c < N; c++) begin
        check($sformatf("%s tx bit%0d c%0d", name, i, c), {31'd0, bus.tx}, {31'd0, exp[i]});
        if (c == 0) begin
          rx[i] = bus.tx;
          check($sformatf("%s busy bit%0d", name, i), {31'd0, bus.busy}, 32'd1);
          check($sformatf("%s ready bit%0d", name, i), {31'd0, bus.ready}, 32'd0);
          check($sformatf("%s done bit%0d", name, i), {31'd0, bus.done}, 32'd0);
        end
        if (scramble) begin
          bus.data = 4'($urandom);
          bus.trig = 1'($urandom);
        end
        step();
      end
    end
    check({name, " end tx"},    {31'd0, bus.tx},    32'd1);
    check({name, " end busy"},  {31'd0, bus.busy},  32'd0);
    check({name, " end ready"}, {31'd0, bus.ready}, 32'd1);
    check({name, " end done"},  {31'd0, bus.done},  32'd1);
    // receiver-side parity check: 0 means the frame passes
    chk_out = rx[5] ^ (^rx[4:1]) ^ trig_sent;
    check({name, " checker out"}, {31'd0, chk_out}, {31'd0, exp_chk});
  endtask

  task automatic send(input logic [3:0] d, input logic t, input logic [6:0] exp,
                      input bit scramble, input string name);
    check({name, " ready before"}, {31'd0, bus.ready}, 32'd1);
    bus.valid = 1'b1;
    bus.data  = d;
    bus.trig  = t;
    step();
    bus.valid = 1'b0;
    check_frame(exp, t, scramble, 1'b0, name);
    step();
    check({name, " done cleared"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    bus.valid = 1'b0;
    bus.data  = 4'd0;
    bus.trig  = 1'b0;
`ifdef PARITY_TX_ERR_INJ_EN
    bus.err_inj = 1'b0;
`endif

    vecs[0] = '{4'b1011, 1'b0, 7'b1110110};
    vecs[1] = '{4'b1011, 1'b1, 7'b1010110};
    vecs[2] = '{4'b0000, 1'b0, 7'b1000000};
    vecs[3] = '{4'b0000, 1'b1, 7'b1100000};
    vecs[4] = '{4'b1111, 1'b1, 7'b1111110};
    vecs[5] = '{4'b0110, 1'b0, 7'b1001100};

    #12;
    check("reset tx",    {31'd0, bus.tx},    32'd1);
    check("reset ready", {31'd0, bus.ready}, 32'd1);
    check("reset busy",  {31'd0, bus.busy},  32'd0);
    check("reset done",  {31'd0, bus.done},  32'd0);
    rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      step();
      check($sformatf("idle tx c%0d", c),    {31'd0, bus.tx},    32'd1);
      check($sformatf("idle ready c%0d", c), {31'd0, bus.ready}, 32'd1);
      check($sformatf("idle busy c%0d", c),  {31'd0, bus.busy},  32'd0);
      check($sformatf("idle done c%0d", c),  {31'd0, bus.done},  32'd0);
    end

    for (int v = 0; v < 6; v++)
      send(vecs[v].data, vecs[v].trig, vecs[v].frame, (v % 2) == 1, $sformatf("vec%0d", v));

    // valid held high: 0xA then 0x5; data changes right after the first accept
    bus.valid = 1'b1;
    bus.data  = 4'hA;
    bus.trig  = 1'b0;
    step();
    bus.data  = 4'h5;
    check_frame(7'b1010100, 1'b0, 1'b0, 1'b0, "b2b first");
    step();
    check("b2b second accepted ready", {31'd0, bus.ready}, 32'd0);
    check("b2b second start tx",      {31'd0, bus.tx},    32'd0);
    check("b2b done cleared",         {31'd0, bus.done},  32'd0);
    bus.valid = 1'b0;
    check_frame(7'b1001010, 1'b0, 1'b1, 1'b0, "b2b second");
    step();
    check("b2b idle after", {31'd0, bus.tx}, 32'd1);

    // reset in the middle of DATA
    bus.valid = 1'b1;
    bus.data  = 4'b1011;
    bus.trig  = 1'b0;
    step();
    bus.valid = 1'b0;
    for (int c = 0; c < N + 2; c++) step();
    check("pre-reset busy", {31'd0, bus.busy}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst tx",    {31'd0, bus.tx},    32'd1);
    check("midrst ready", {31'd0, bus.ready}, 32'd1);
    check("midrst busy",  {31'd0, bus.busy},  32'd0);
    for (int c = 0; c < 2; c++) begin
      step();
      check($sformatf("midrst done c%0d", c), {31'd0, bus.done}, 32'd0);
      check($sformatf("midrst tx c%0d", c),   {31'd0, bus.tx},    32'd1);
    end
    rst_n = 1'b1;
    step();
    send(4'b1011, 1'b0, 7'b1110110, 1'b0, "after reset");

`ifdef PARITY_TX_ERR_INJ_EN
    bus.valid   = 1'b1;
    bus.data    = 4'b1011;
    bus.trig    = 1'b0;
    bus.err_inj = 1'b1;
    step();
    bus.valid   = 1'b0;
    bus.err_inj = 1'b0;
    check_frame(7'b1010110, 1'b0, 1'b0, 1'b1, "inj on");
    step();
    send(4'b1011, 1'b0, 7'b1110110, 1'b0, "inj off");
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, tests %0d", n_tests);
    $fatal(1, "timeout");
  end
endmodule
